alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 196 +++++++++++++++++++
 tb/tb_alu_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Brief    : Multi-slice ALU sequencer, one SLICE-bit slice per clock,
//             start/ready/done handshake and persistent carry flag.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_SHL  = 4'd1;
    localparam logic [3:0] OP_SHR  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_ADDC = 4'd4;
    localparam logic [3:0] OP_INC  = 4'd5;
    localparam logic [3:0] OP_INCC = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_SUBB = 4'd8;
    localparam logic [3:0] OP_DEC  = 4'd9;
    localparam logic [3:0] OP_AND  = 4'd10;
    localparam logic [3:0] OP_OR   = 4'd11;
    localparam logic [3:0] OP_XOR  = 4'd12;
    localparam logic [3:0] OP_NOT  = 4'd13;

    generate
        if ((WIDTH < SLICE) || (WIDTH % SLICE != 0)) begin : g_bad_param
            $error("alu_seq: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   lhs_q;
    logic [WIDTH-1:0]   rhs_q;
    logic               chain_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic               zero_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;

    logic [CW-1:0]      w_pos;
    int                 w_base;
    logic [SLICE-1:0]   w_a;
    logic [SLICE-1:0]   w_b;
    logic [SLICE-1:0]   w_b_op;
    logic [SLICE:0]     w_sum;
    logic [SLICE-1:0]   w_slice;
    logic               w_cout;
    logic               cin_d;
    logic [WIDTH-1:0]   result_d;

    // Carry-in of slice 0, chosen from the incoming opcode and the flag at accept.
    always_comb begin
        cin_d = 1'b0;
        case (operation)
            OP_ADDC, OP_INCC, OP_SUBB: cin_d = carry_q;
            OP_INC, OP_SUB:            cin_d = 1'b1;
            default:                   cin_d = 1'b0;
        endcase
    end

    always_comb begin
        w_pos  = (op_q == OP_SHR) ? (LAST - cnt_q) : cnt_q;
        w_base = int'(w_pos) * SLICE;
        w_a    = lhs_q[w_base +: SLICE];
        w_b    = rhs_q[w_base +: SLICE];

        w_b_op = '0;
        case (op_q)
            OP_ADD, OP_ADDC: w_b_op = w_b;
            OP_SUB, OP_SUBB: w_b_op = ~w_b;
            OP_DEC:          w_b_op = '1;
            default:         w_b_op = '0;
        endcase
        w_sum = {1'b0, w_a} + {1'b0, w_b_op} + {{SLICE{1'b0}}, chain_q};

        w_slice = '0;
        w_cout  = 1'b0;
        case (op_q)
            OP_SHL:  {w_cout, w_slice} = {w_a, chain_q};
            OP_SHR:  {w_slice, w_cout} = {chain_q, w_a};
            OP_ADD, OP_ADDC, OP_INC, OP_INCC,
            OP_SUB, OP_SUBB, OP_DEC:
                     {w_cout, w_slice} = w_sum;
            OP_AND:  w_slice = w_a & w_b;
            OP_OR:   w_slice = w_a | w_b;
            OP_XOR:  w_slice = w_a ^ w_b;
            OP_NOT:  w_slice = ~w_b;
            default: begin
                w_slice = '0;
                w_cout  = 1'b0;
            end
        endcase

        result_d = result_q;
        result_d[w_base +: SLICE] = w_slice;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            lhs_q    <= '0;
            rhs_q    <= '0;
            chain_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= operation;
                        lhs_q   <= lhs;
                        rhs_q   <= rhs;
                        chain_q <= cin_d;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        // nop never clocks the datapath: result and flags hold.
                        if (operation == OP_NOP) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    result_q <= result_d;
                    chain_q  <= w_cout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        carry_q <= w_cout;
                        zero_q  <= (result_d == '0);
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Brief    : Directed vector bench for alu_seq at 16/8, 32/8 and 8/8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_SHL  = 4'd1;
    localparam logic [3:0] OP_SHR  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_ADDC = 4'd4;
    localparam logic [3:0] OP_INC  = 4'd5;
    localparam logic [3:0] OP_INCC = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_SUBB = 4'd8;
    localparam logic [3:0] OP_DEC  = 4'd9;
    localparam logic [3:0] OP_AND  = 4'd10;
    localparam logic [3:0] OP_OR   = 4'd11;
    localparam logic [3:0] OP_XOR  = 4'd12;
    localparam logic [3:0] OP_NOT  = 4'd13;
    localparam logic [3:0] OP_CLC  = 4'd14;
    localparam logic [3:0] OP_RSV  = 4'd15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  operation;
    logic        start16, start32, start8;
    logic [15:0] lhs16, rhs16, result16;
    logic [31:0] lhs32, rhs32, result32;
    logic [7:0]  lhs8, rhs8, result8;
    logic        ready16, busy16, done16, carry16, zero16;
    logic        ready32, busy32, done32, carry32, zero32;
    logic        ready8, busy8, done8, carry8, zero8;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(16), .SLICE(8)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .operation(operation),
        .lhs(lhs16), .rhs(rhs16), .ready(ready16), .busy(busy16), .done(done16),
        .result(result16), .carry(carry16), .zero(zero16));

    alu_seq #(.WIDTH(32), .SLICE(8)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .operation(operation),
        .lhs(lhs32), .rhs(rhs32), .ready(ready32), .busy(busy32), .done(done32),
        .result(result32), .carry(carry32), .zero(zero32));

    alu_seq #(.WIDTH(8), .SLICE(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .operation(operation),
        .lhs(lhs8), .rhs(rhs8), .ready(ready8), .busy(busy8), .done(done8),
        .result(result8), .carry(carry8), .zero(zero8));

    typedef struct {
        logic [3:0]  op;
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] res;
        logic        c;
        logic        z;
    } vec_t;

    vec_t vt [0:24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic dn(input int w);
        case (w)
            32:      return done32;
            8:       return done8;
            default: return done16;
        endcase
    endfunction

    function automatic logic [31:0] res(input int w);
        case (w)
            32:      return result32;
            8:       return {24'h0, result8};
            default: return {16'h0, result16};
        endcase
    endfunction

    function automatic logic cy(input int w);
        case (w)
            32:      return carry32;
            8:       return carry8;
            default: return carry16;
        endcase
    endfunction

    function automatic logic zr(input int w);
        case (w)
            32:      return zero32;
            8:       return zero8;
            default: return zero16;
        endcase
    endfunction

    // Launch one op on the selected instance, scramble inputs after accept,
    // and count edges (accept edge = 1) until done is seen.
    task automatic run_op(input int w, input logic [3:0] op, input logic [31:0] l,
                          input logic [31:0] r, output int lat);
        @(negedge clk);
        operation = op;
        case (w)
            32:      begin lhs32 = l;        rhs32 = r;        start32 = 1'b1; end
            8:       begin lhs8  = l[7:0];   rhs8  = r[7:0];   start8  = 1'b1; end
            default: begin lhs16 = l[15:0];  rhs16 = r[15:0];  start16 = 1'b1; end
        endcase
        @(negedge clk);
        start16 = 1'b0; start32 = 1'b0; start8 = 1'b0;
        operation = ~op;
        lhs16 = ~lhs16; rhs16 = ~rhs16;
        lhs32 = ~lhs32; rhs32 = ~rhs32;
        lhs8  = ~lhs8;  rhs8  = ~rhs8;
        lat = 1;
        while (dn(w) !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic width_case(input int w, input logic [3:0] op,
                              input logic [31:0] l_in, input logic [31:0] r_in);
        logic [32:0] full;
        logic [31:0] mask, l, r, er;
        logic        ec;
        int          lat;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        l = l_in & mask;
        r = r_in & mask;
        if (op == OP_ADD) begin
            full = {1'b0, l} + {1'b0, r};
            er   = full[31:0] & mask;
            ec   = full[w];
        end else if (op == OP_SHL) begin
            er = (l << 1) & mask;
            ec = l[w-1];
        end else begin
            er = l >> 1;
            ec = l[0];
        end
        run_op(w, op, l, r, lat);
        chk($sformatf("w%0d_op%0d_lat", w, op), lat, w / 8 + 1);
        chk($sformatf("w%0d_op%0d_res", w, op), res(w), er);
        chk($sformatf("w%0d_op%0d_carry", w, op), {31'h0, cy(w)}, {31'h0, ec});
        chk($sformatf("w%0d_op%0d_zero", w, op), {31'h0, zr(w)}, {31'h0, er == 32'h0});
    endtask

    initial begin
        int lat;
        int ndone;
        logic [15:0] seen;

        vt[0]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vt[1]  = '{OP_ADDC, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};
        vt[2]  = '{OP_SUB,  16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0};
        vt[3]  = '{OP_SUBB, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vt[4]  = '{OP_DEC,  16'h0000, 16'h5555, 16'hFFFF, 1'b0, 1'b0};
        vt[5]  = '{OP_SHL,  16'h8080, 16'h0000, 16'h0100, 1'b1, 1'b0};
        vt[6]  = '{OP_SHR,  16'h0101, 16'h0000, 16'h0080, 1'b1, 1'b0};
        vt[7]  = '{OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
        vt[8]  = '{OP_INCC, 16'h00FF, 16'h0000, 16'h00FF, 1'b0, 1'b0};
        vt[9]  = '{OP_INC,  16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vt[10] = '{OP_INCC, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0};
        vt[11] = '{OP_OR,   16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0};
        vt[12] = '{OP_XOR,  16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1};
        vt[13] = '{OP_NOT,  16'h1234, 16'h00FF, 16'hFF00, 1'b0, 1'b0};
        vt[14] = '{OP_SUBB, 16'h0005, 16'h0003, 16'h0001, 1'b1, 1'b0};
        vt[15] = '{OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};
        vt[16] = '{OP_ADDC, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0};
        vt[17] = '{OP_ADD,  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vt[18] = '{OP_CLC,  16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1};
        vt[19] = '{OP_ADD,  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vt[20] = '{OP_RSV,  16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1};
        vt[21] = '{OP_DEC,  16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vt[22] = '{OP_ADD,  16'h9234, 16'h8000, 16'h1234, 1'b1, 1'b0};
        vt[23] = '{OP_NOP,  16'hFFFF, 16'hFFFF, 16'h1234, 1'b1, 1'b0};
        vt[24] = '{OP_ADDC, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0};

        reset = 1'b1;
        start16 = 1'b0; start32 = 1'b0; start8 = 1'b0;
        operation = OP_NOP;
        lhs16 = '0; rhs16 = '0; lhs32 = '0; rhs32 = '0; lhs8 = '0; rhs8 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_ready", {31'h0, ready16}, 32'd1);
        chk("rst_busy",  {31'h0, busy16},  32'd0);
        chk("rst_done",  {31'h0, done16},  32'd0);
        chk("rst_result", {16'h0, result16}, 32'h0);
        chk("rst_carry", {31'h0, carry16}, 32'd0);
        chk("rst_zero",  {31'h0, zero16},  32'd0);
        chk("rst_ready32_8", {30'h0, ready32, ready8}, 32'd3);

        // First add with cycle-by-cycle handshake observation.
        @(negedge clk);
        operation = OP_ADD; lhs16 = 16'h00FF; rhs16 = 16'h0001; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        chk("hs_c1_ready", {31'h0, ready16}, 32'd0);
        chk("hs_c1_busy",  {31'h0, busy16},  32'd1);
        chk("hs_c1_done",  {31'h0, done16},  32'd0);
        @(negedge clk);
        chk("hs_c2_ready", {31'h0, ready16}, 32'd0);
        chk("hs_c2_done",  {31'h0, done16},  32'd0);
        @(negedge clk);
        chk("hs_c3_ready", {31'h0, ready16}, 32'd0);
        chk("hs_c3_done",  {31'h0, done16},  32'd1);
        chk("hs_c3_busy",  {31'h0, busy16},  32'd0);
        chk("hs_result", {16'h0, result16}, 32'h0100);
        chk("hs_carry",  {31'h0, carry16}, 32'd0);
        chk("hs_zero",   {31'h0, zero16},  32'd0);
        @(negedge clk);
        chk("hs_c4_ready", {31'h0, ready16}, 32'd1);
        chk("hs_c4_done",  {31'h0, done16},  32'd0);

        for (int i = 0; i < 25; i++) begin
            run_op(16, vt[i].op, {16'h0, vt[i].l}, {16'h0, vt[i].r}, lat);
            chk($sformatf("v%0d_lat", i), lat, (vt[i].op == OP_NOP) ? 32'd1 : 32'd3);
            chk($sformatf("v%0d_res", i), {16'h0, result16}, {16'h0, vt[i].res});
            chk($sformatf("v%0d_carry", i), {31'h0, carry16}, {31'h0, vt[i].c});
            chk($sformatf("v%0d_zero", i), {31'h0, zero16}, {31'h0, vt[i].z});
        end

        // start held during RUN must be ignored.
        @(negedge clk);
        operation = OP_ADD; lhs16 = 16'h0001; rhs16 = 16'h0002; start16 = 1'b1;
        @(negedge clk);
        operation = OP_SUB; lhs16 = 16'hFFFF;
        @(negedge clk);
        start16 = 1'b0;
        ndone = 0;
        seen = 16'hDEAD;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done16 === 1'b1) begin
                ndone++;
                seen = result16;
            end
        end
        chk("busy_start_ndone", ndone, 32'd1);
        chk("busy_start_res", {16'h0, seen}, 32'h0003);

        run_op(16, OP_ADD, 32'h9234, 32'h8000, lat);
        chk("pre_rst_res", {16'h0, result16}, 32'h1234);
        chk("pre_rst_carry", {31'h0, carry16}, 32'd1);

        // Reset in the middle of RUN.
        @(negedge clk);
        operation = OP_ADD; lhs16 = 16'h0001; rhs16 = 16'h0001; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_ready", {31'h0, ready16}, 32'd1);
        chk("mid_rst_busy",  {31'h0, busy16},  32'd0);
        chk("mid_rst_done",  {31'h0, done16},  32'd0);
        chk("mid_rst_result", {16'h0, result16}, 32'h0);
        chk("mid_rst_carry", {31'h0, carry16}, 32'd0);
        chk("mid_rst_zero",  {31'h0, zero16},  32'd0);
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done16 === 1'b1) ndone++;
        end
        chk("mid_rst_no_done", ndone, 32'd0);
        run_op(16, OP_ADD, 32'h7FFF, 32'h0001, lat);
        chk("post_rst_lat", lat, 32'd3);
        chk("post_rst_res", {16'h0, result16}, 32'h8000);
        chk("post_rst_carry", {31'h0, carry16}, 32'd0);

        width_case(32, OP_ADD, 32'h0000_FFFF, 32'h0000_0001);
        width_case(32, OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        width_case(32, OP_ADD, 32'h8000_0000, 32'h8000_0000);
        width_case(32, OP_SHR, 32'h0101_0101, 32'h0);
        width_case(32, OP_SHR, 32'h8000_0000, 32'h0);
        width_case(8,  OP_ADD, 32'hFF, 32'h01);
        width_case(8,  OP_ADD, 32'h12, 32'h34);
        width_case(8,  OP_SHR, 32'h81, 32'h0);
        width_case(8,  OP_SHL, 32'h81, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
